// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

    localparam int REG_IDX_W           = 4;
    localparam int MEM_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ERR
    } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational data-hazard detector for the ID stage.
// HAZ_FORWARDING_EN selects load-use-only detection; otherwise any RAW against EXE/MEM stalls.
module hazard_detect
    import hazard_pkg::*;
(
    input  logic [REG_IDX_W-1:0] src1,
    input  logic [REG_IDX_W-1:0] src2,
    input  logic                 src1_vld,
    input  logic                 src2_vld,
    input  logic [REG_IDX_W-1:0] exe_dest,
    input  logic                 exe_wb_en,
    input  logic                 exe_mem_r_en,
    input  logic [REG_IDX_W-1:0] mem_dest,
    input  logic                 mem_wb_en,
    output logic                 data_haz
);

`ifdef HAZ_FORWARDING_EN
    // The forwarding network covers every RAW except a load whose data is not back yet.
    logic unused_mem_fields;
    assign unused_mem_fields = ^{mem_wb_en, mem_dest};

    assign data_haz = exe_mem_r_en && exe_wb_en &&
                      ((src1_vld && (src1 == exe_dest)) ||
                       (src2_vld && (src2 == exe_dest)));
`else
    logic unused_load_flag;
    logic raw_src1;
    logic raw_src2;
    assign unused_load_flag = exe_mem_r_en;

    assign raw_src1 = src1_vld && ((exe_wb_en && (exe_dest == src1)) ||
                                   (mem_wb_en && (mem_dest == src1)));
    assign raw_src2 = src2_vld && ((exe_wb_en && (exe_dest == src2)) ||
                                   (mem_wb_en && (mem_dest == src2)));
    assign data_haz = raw_src1 || raw_src2;
`endif

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Freeze/flush controller for the 5-stage core: SRAM-wait FSM with timeout,
// priority strobe mux and saturating counters. Option macro: HAZ_FORWARDING_EN.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] src1,
    input  logic [REG_IDX_W-1:0] src2,
    input  logic                 src1_vld,
    input  logic                 src2_vld,
    input  logic [REG_IDX_W-1:0] exe_dest,
    input  logic                 exe_wb_en,
    input  logic                 exe_mem_r_en,
    input  logic                 exe_b_taken,
    input  logic [REG_IDX_W-1:0] mem_dest,
    input  logic                 mem_wb_en,
    input  logic                 mem_req,
    input  logic                 sram_ready,
    output logic                 if_freeze,
    output logic                 id_freeze,
    output logic                 ex_freeze,
    output logic                 if_flush,
    output logic                 id_flush,
    output logic                 mem_err,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               mem_err_q, mem_err_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic               data_haz;
    logic               mem_stall;
    logic               branch_flush;

    hazard_detect u_detect (
        .src1         (src1),
        .src2         (src2),
        .src1_vld     (src1_vld),
        .src2_vld     (src2_vld),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .data_haz     (data_haz)
    );

    always_comb begin : fsm_next
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            IDLE: begin
                if (mem_req && !sram_ready) begin
                    state_d    = WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            WAIT: begin
                if (sram_ready) begin
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) begin
                    state_d   = ERR;
                    mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    // A held MEM stage outranks everything: a pending branch or hazard must wait for EXE to move.
    always_comb begin : strobe_mux
        if_freeze    = 1'b0;
        id_freeze    = 1'b0;
        ex_freeze    = 1'b0;
        if_flush     = 1'b0;
        id_flush     = 1'b0;
        branch_flush = 1'b0;
        mem_stall    = (state_q == WAIT) || (state_q == ERR) ||
                       ((state_q == IDLE) && mem_req && !sram_ready);
        if (mem_stall) begin
            if_freeze = 1'b1;
            id_freeze = 1'b1;
            ex_freeze = 1'b1;
        end else if (exe_b_taken) begin
            if_flush     = 1'b1;
            id_flush     = 1'b1;
            branch_flush = 1'b1;
        end else if (data_haz) begin
            if_freeze = 1'b1;
            id_flush  = 1'b1;
        end
    end

    always_comb begin : counters_next
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (if_freeze && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (branch_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
